// File: rtl/async_lock_pkg.sv
// Shared types for the clocked scheduler that fronts a two-input asynchronous mutex.
package async_lock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } lock_state_t;

  localparam int NUM_CLIENTS = 2;

endpackage

// File: rtl/sync_nff.sv
// N-flop synchroniser for one asynchronous bit, cleared to 0 by reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* keep = "true" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/async_mutex_sched.sv
// Two-client four-phase lock scheduler around an unclocked mutex: synchronised grants,
// alternation under contention, hold timeout with revoke/lockout, sticky double-grant error.
module async_mutex_sched
  import async_lock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cli_req,
  output logic [1:0] cli_gnt,
  output logic [1:0] cli_revoke,
  output logic [1:0] mtx_req,
  input  logic [1:0] mtx_gnt,
  output logic       err
);

  localparam int            CW         = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX_C = CW'(HOLD_MAX);

  logic [NUM_CLIENTS-1:0] w_gs;
  lock_state_t            w_st [NUM_CLIENTS];
  logic                   r_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      localparam int OJ = NUM_CLIENTS - 1 - gi;

      lock_state_t   r_state, w_state_next;
      logic [CW-1:0] r_hold_cnt, w_hold_cnt_next;
      logic          r_gnt, r_mtx, r_rev, r_lockout, r_yield;
      logic          w_gnt_next, w_mtx_next, w_rev_next, w_lockout_next, w_yield_next;
      logic          w_yield, w_timeout, w_other_req;

      sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mtx_gnt[gi]),
        .q     (w_gs[gi])
      );

      // Yield is remembered past REL->IDLE so a fast re-request cannot jump the waiter.
      assign w_other_req = (w_st[OJ] == REQ);
      assign w_yield     = r_yield & w_other_req;
      assign w_timeout   = (HOLD_MAX != 0) && (r_state == HELD) &&
                           (r_hold_cnt == HOLD_MAX_C) && cli_req[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
          r_gnt      <= 1'b0;
          r_mtx      <= 1'b0;
          r_rev      <= 1'b0;
          r_lockout  <= 1'b0;
          r_yield    <= 1'b0;
        end else begin
          r_state    <= w_state_next;
          r_hold_cnt <= w_hold_cnt_next;
          r_gnt      <= w_gnt_next;
          r_mtx      <= w_mtx_next;
          r_rev      <= w_rev_next;
          r_lockout  <= w_lockout_next;
          r_yield    <= w_yield_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        unique case (r_state)
          IDLE: if (cli_req[gi] && !r_lockout && !w_yield) w_state_next = REQ;
          REQ:  if (!cli_req[gi]) w_state_next = REL;
                else if (w_gs[gi]) w_state_next = HELD;
          HELD: if (!cli_req[gi] || w_timeout) w_state_next = REL;
          REL:  if (!w_gs[gi]) w_state_next = IDLE;
        endcase
      end

      // Next values for the registered outputs, so mtx_req/cli_gnt leave straight from flops.
      always_comb begin
        w_mtx_next      = (w_state_next == REQ) || (w_state_next == HELD);
        w_gnt_next      = (w_state_next == HELD);
        w_rev_next      = w_timeout;
        w_lockout_next  = r_lockout;
        if (w_timeout) w_lockout_next = 1'b1;
        else if (!cli_req[gi]) w_lockout_next = 1'b0;
        w_hold_cnt_next = '0;
        if ((r_state == HELD) && (w_state_next == HELD))
          w_hold_cnt_next = (r_hold_cnt == HOLD_MAX_C) ? r_hold_cnt : r_hold_cnt + CW'(1);
        w_yield_next    = r_yield;
        if ((r_state == REL) && w_other_req) w_yield_next = 1'b1;
        else if (!w_other_req) w_yield_next = 1'b0;
      end

      assign w_st[gi]       = r_state;
      assign cli_gnt[gi]    = r_gnt;
      assign mtx_req[gi]    = r_mtx;
      assign cli_revoke[gi] = r_rev;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (&w_gs) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_async_mutex_sched.sv
// Directed bench for async_mutex_sched with a behavioural two-input mutex (random small grant delay).
module tb_async_mutex_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cli_req, cli_gnt, cli_revoke, mtx_req, mtx_gnt;
  logic [1:0] m_gnt, f_val;
  logic       err, f_en;
  int         total = 0;
  int         bad   = 0;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] mtx;
    logic [1:0] rev;
  } vec_t;
  vec_t vecs[$];

  async_mutex_sched #(.SYNC_STAGES(2), .HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cli_req    (cli_req),
    .cli_gnt    (cli_gnt),
    .cli_revoke (cli_revoke),
    .mtx_req    (mtx_req),
    .mtx_gnt    (mtx_gnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign mtx_gnt = f_en ? f_val : m_gnt;

  // Mutex model: release follows req drop within 1ns, grant follows 1-3ns after a free mutex sees a request.
  int m_wait;
  initial begin
    m_gnt  = 2'b00;
    m_wait = -1;
    forever begin
      #1;
      if (m_gnt[0] && !mtx_req[0]) m_gnt[0] = 1'b0;
      if (m_gnt[1] && !mtx_req[1]) m_gnt[1] = 1'b0;
      if (m_gnt == 2'b00 && mtx_req != 2'b00) begin
        if (m_wait < 0) m_wait = int'($urandom_range(2, 0));
        else if (m_wait == 0) begin
          m_wait = -1;
          if (mtx_req == 2'b11) m_gnt = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
          else m_gnt = mtx_req;
        end else m_wait--;
      end else begin
        m_wait = -1;
      end
    end
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(int n, logic [1:0] req, logic [1:0] gnt, logic [1:0] mtx, logic [1:0] rev);
    for (int k = 0; k < n; k++) vecs.push_back(vec_t'{req, gnt, mtx, rev});
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, err, cli_revoke, mtx_req, cli_gnt};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("gnt_exclusive", {7'd0, cli_gnt == 2'b11}, 8'd0);
  end

  initial begin
    int n;
    int w;
    logic [1:0] wb, lb;

    rst_n = 1'b0; cli_req = 2'b00; f_en = 1'b0; f_val = 2'b00;

    // Client 0 uncontended: grant after edge 3, release, REL blocks re-request until IDLE.
    add(3, 2'b01, 2'b00, 2'b01, 2'b00);
    add(4, 2'b01, 2'b01, 2'b01, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b01, 2'b00, 2'b00, 2'b00);
    add(3, 2'b01, 2'b00, 2'b01, 2'b00);
    add(1, 2'b01, 2'b01, 2'b01, 2'b00);
    add(4, 2'b00, 2'b00, 2'b00, 2'b00);
    // Client 1 timeout: 5 held cycles, revoke pulse, lockout until req seen low.
    add(3, 2'b10, 2'b00, 2'b10, 2'b00);
    add(5, 2'b10, 2'b10, 2'b10, 2'b00);
    add(1, 2'b10, 2'b00, 2'b00, 2'b10);
    add(5, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b10, 2'b00, 2'b10, 2'b00);
    add(1, 2'b10, 2'b10, 2'b10, 2'b00);
    add(4, 2'b00, 2'b00, 2'b00, 2'b00);

    #2 chk("reset_outs", outs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cli_req = vecs[i].req;
      step();
      $display("vec %0d req=%b gnt=%b mtx=%b rev=%b err=%b", i, cli_req, cli_gnt, mtx_req, cli_revoke, err);
      chk($sformatf("vec%0d", i), outs(), {2'b00, vecs[i].rev, vecs[i].mtx, vecs[i].gnt});
    end

    // Contention: both request together, mutex picks one; handover to the loser, winner waits.
    cli_req = 2'b11;
    step();
    chk("contend_mtx", {mtx_req, cli_gnt}, 8'b1100);
    n = 0;
    while (cli_gnt == 2'b00 && n < 10) begin step(); n++; end
    chk("contend_latency", 8'(n), 8'd3);
    chk("contend_onehot", {7'd0, (cli_gnt == 2'b01) || (cli_gnt == 2'b10)}, 8'd1);
    w  = cli_gnt[1] ? 1 : 0;
    wb = (w == 1) ? 2'b10 : 2'b01;
    lb = ~wb;
    $display("contend winner=%0d", w);
    cli_req = lb;
    step();
    chk("winner_release", {mtx_req, cli_gnt}, {lb, 2'b00});
    cli_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("winner_waits", {mtx_req, cli_gnt}, {lb, 2'b00});
    end
    step();
    chk("loser_granted", {mtx_req, cli_gnt}, {lb, lb});
    step();
    chk("winner_rereq", {mtx_req, cli_gnt}, {2'b11, lb});
    cli_req = wb;
    step();
    chk("loser_release", {mtx_req, cli_gnt}, {wb, 2'b00});
    n = 0;
    while (cli_gnt == 2'b00 && n < 10) begin step(); n++; end
    chk("handover_latency", 8'(n), 8'd3);
    chk("handover_owner", {6'd0, cli_gnt}, {6'd0, wb});
    cli_req = 2'b00;
    repeat (5) step();

    // Abandon: client 0 requests while client 1 holds, then drops before any grant.
    cli_req = 2'b10;
    repeat (4) step();
    chk("abandon_owner", {mtx_req, cli_gnt}, 8'b1010);
    cli_req = 2'b11;
    step();
    chk("abandon_req", {mtx_req, cli_gnt}, 8'b1110);
    cli_req = 2'b10;
    step();
    chk("abandon_drop", {mtx_req, cli_gnt}, 8'b1010);
    step();
    chk("abandon_nognt", {mtx_req, cli_gnt}, 8'b1010);
    cli_req = 2'b00;
    step();
    chk("abandon_end", outs(), 8'h00);
    repeat (4) step();

    // Reset mid-HELD, then a normal grant in S+1 cycles.
    cli_req = 2'b01;
    repeat (4) step();
    chk("pre_reset_held", {6'd0, cli_gnt}, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", outs(), 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_reset_e%0d", k), {mtx_req, cli_gnt}, {2'b01, (k == 3) ? 2'b01 : 2'b00});
    end
    cli_req = 2'b00;
    repeat (5) step();

    // Fault inject: both grants high for 3 cycles sets sticky err.
    chk("err_clear", {7'd0, err}, 8'd0);
    f_val = 2'b11;
    f_en  = 1'b1;
    repeat (3) step();
    f_en = 1'b0;
    chk("err_set", {7'd0, err}, 8'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("err_sticky", {7'd0, err}, 8'd1);
    end
    rst_n = 1'b0;
    #1 chk("err_reset", outs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("final_idle", outs(), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
